crc_frame_receiver: RTL and testbench

- Receive end of the serial CRC link: consumes the serial/enable bit stream produced by the parallel_to_serial + crc pair.
- Frame = DATA_WIDTH payload bits followed by CRC_SIZE check bits, both MSB first.
- Deserializes the payload, recomputes the CRC over it, compares against the received check field, and reports the parallel word with a pass/fail flag.
- Sits between the serial link and downstream parallel consumers.

---
 rtl/crc_frame_receiver.sv | 173 +++++++++++++++++
 tb/tb_crc_frame_receiver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_receiver.sv
// crc_frame_receiver: deserializes MSB-first payload+CRC frames from a serial/enable link and checks the CRC.
// Latency: results and valid appear one cycle after the last check bit. No backpressure: every enabled bit is consumed. Optional CRC_ERR_CNT_EN adds err_cnt.
module crc_frame_receiver #(
    parameter int                  DATA_WIDTH = 128,
    parameter int                  CRC_SIZE   = 32,
    parameter logic [CRC_SIZE-1:0] INITAL_VAL = 32'h00000000,
    parameter logic [CRC_SIZE-1:0] CRC_POLY   = 32'h04C11DB7,
    parameter logic [CRC_SIZE-1:0] FINAL_XOR  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CRC_SIZE-1:0]   crc_rx,
    output logic [CRC_SIZE-1:0]   crc_calc,
    output logic                  valid,
    output logic                  crc_ok,
    output logic                  busy,
    output logic                  frame_err
`ifdef CRC_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam int MAX_W = (DATA_WIDTH > CRC_SIZE) ? DATA_WIDTH : CRC_SIZE;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CRC_SIZE - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] pay_sr;
    logic [CRC_SIZE-1:0]   chk_sr;
    logic [CRC_SIZE-1:0]   lfsr;

    logic                  pay_last;
    logic                  chk_last;
    logic                  pay_shift;
    logic                  chk_shift;
    logic                  done;
    logic                  abort;
    logic [DATA_WIDTH-1:0] pay_nxt;
    logic [CRC_SIZE-1:0]   chk_nxt;
    logic [CRC_SIZE-1:0]   lfsr_nxt;
    logic [CRC_SIZE-1:0]   crc_fin;

    assign pay_last = (bit_cnt == PAY_LAST);
    assign chk_last = (bit_cnt == CHK_LAST);

    // Truncating casts keep the shift expressions legal for 1-bit widths.
    assign pay_nxt  = DATA_WIDTH'({pay_sr, serial});
    assign chk_nxt  = CRC_SIZE'({chk_sr, serial});
    assign lfsr_nxt = CRC_SIZE'({lfsr, 1'b0}) ^
                      ((lfsr[CRC_SIZE-1] ^ serial) ? CRC_POLY : '0);
    assign crc_fin  = lfsr ^ FINAL_XOR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = (DATA_WIDTH == 1) ? CHECK : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (pay_last) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!enable || chk_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        pay_shift = 1'b0;
        chk_shift = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                pay_shift = enable;
            end
            PAYLOAD: begin
                busy      = 1'b1;
                pay_shift = enable;
                abort     = !enable;
            end
            CHECK: begin
                busy      = 1'b1;
                chk_shift = enable;
                done      = enable && chk_last;
                abort     = !enable;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            pay_sr    <= '0;
            chk_sr    <= '0;
            lfsr      <= INITAL_VAL;
            data_out  <= '0;
            crc_rx    <= '0;
            crc_calc  <= '0;
            crc_ok    <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= done;
            frame_err <= abort;
            if (pay_shift) begin
                pay_sr <= pay_nxt;
                lfsr   <= lfsr_nxt;
            end
            if (chk_shift) begin
                chk_sr <= chk_nxt;
            end
            // Check bits only touch chk_sr, so pay_sr already holds the full payload here.
            if (done) begin
                data_out <= pay_sr;
                crc_rx   <= chk_nxt;
                crc_calc <= crc_fin;
                crc_ok   <= (chk_nxt == crc_fin);
            end
            if (done || abort) begin
                lfsr    <= INITAL_VAL;
                bit_cnt <= '0;
            end else if (pay_shift) begin
                bit_cnt <= pay_last ? '0 : bit_cnt + CNT_W'(1);
            end else if (chk_shift) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef CRC_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (((done && (chk_nxt != crc_fin)) || abort) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc_frame_receiver.sv
// Directed bench for crc_frame_receiver: a 72-bit instance (CRC-32/POSIX vectors) and a default 128-bit instance.
module tb_crc_frame_receiver;

    localparam int DWA = 72;
    localparam int DWB = 128;
    localparam logic [71:0] PAY       = 72'h313233343536373839;
    localparam logic [71:0] PAY3      = 72'hDEADBEEF0123456789;
    localparam logic [31:0] CRC_POSIX = 32'h765E7680;

    logic clk = 1'b0;
    logic rst;
    logic ser_a, en_a, ser_b, en_b;

    logic [DWA-1:0] data_a;
    logic [31:0]    rx_a, calc_a;
    logic           valid_a, ok_a, busy_a, ferr_a;
    logic [DWB-1:0] data_b;
    logic [31:0]    rx_b, calc_b;
    logic           valid_b, ok_b, busy_b, ferr_b;
`ifdef CRC_ERR_CNT_EN
    logic [15:0]    ecnt_a, ecnt_b;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int nval_a = 0, nbad_a = 0, nferr_a = 0, t_val_a = 0, t_prev_a = 0;
    int nv0, nb0, nf0;
    logic [31:0] exp_crc;

    always #5 clk = ~clk;

    crc_frame_receiver #(.DATA_WIDTH(DWA)) dut_a (
        .clk(clk), .rst(rst), .serial(ser_a), .enable(en_a),
        .data_out(data_a), .crc_rx(rx_a), .crc_calc(calc_a), .valid(valid_a),
        .crc_ok(ok_a), .busy(busy_a), .frame_err(ferr_a)
`ifdef CRC_ERR_CNT_EN
        , .err_cnt(ecnt_a)
`endif
    );

    crc_frame_receiver dut_b (
        .clk(clk), .rst(rst), .serial(ser_b), .enable(en_b),
        .data_out(data_b), .crc_rx(rx_b), .crc_calc(calc_b), .valid(valid_b),
        .crc_ok(ok_b), .busy(busy_b), .frame_err(ferr_b)
`ifdef CRC_ERR_CNT_EN
        , .err_cnt(ecnt_b)
`endif
    );

    // Event log for pulse counting and valid spacing on instance A.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid_a) begin
            nval_a   = nval_a + 1;
            t_prev_a = t_val_a;
            t_val_a  = cyc;
            if (!ok_a) nbad_a = nbad_a + 1;
        end
        if (ferr_a) nferr_a = nferr_a + 1;
    end

    function automatic logic [31:0] crc_model(input logic [127:0] d, input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel_b, input logic [255:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (sel_b) begin
                ser_b = v[i];
                en_b  = 1'b1;
            end else begin
                ser_a = v[i];
                en_a  = 1'b1;
            end
        end
    endtask

    task automatic end_frame(input bit sel_b, input string tag, input logic [127:0] exp_d,
                             input logic [31:0] exp_rx, input logic [31:0] exp_calc,
                             input logic exp_ok);
        @(negedge clk);
        en_a = 1'b0;
        en_b = 1'b0;
        chk({tag, ".valid"}, sel_b ? valid_b : valid_a, 1'b1);
        chk({tag, ".data"},  sel_b ? data_b : 128'(data_a), exp_d);
        chk({tag, ".rx"},    sel_b ? rx_b : rx_a, exp_rx);
        chk({tag, ".calc"},  sel_b ? calc_b : calc_a, exp_calc);
        chk({tag, ".ok"},    sel_b ? ok_b : ok_a, exp_ok);
        chk({tag, ".busy"},  sel_b ? busy_b : busy_a, 1'b0);
        @(negedge clk);
        chk({tag, ".valid_off"}, sel_b ? valid_b : valid_a, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        ser_a = 1'b0; en_a = 1'b0;
        ser_b = 1'b0; en_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.data_a", data_a, 0);
        chk("rst.rx_a",   rx_a, 0);
        chk("rst.calc_a", calc_a, 0);
        chk("rst.ok_a",   ok_a, 0);
        chk("rst.valid_a", valid_a, 0);
        chk("rst.busy_a", busy_a, 0);
        chk("rst.ferr_a", ferr_a, 0);
        chk("rst.data_b", data_b, 0);
        chk("rst.calc_b", calc_b, 0);
`ifdef CRC_ERR_CNT_EN
        chk("rst.ecnt_a", ecnt_a, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // CRC-32/POSIX check value over "123456789".
        send(1'b0, {PAY, CRC_POSIX}, 104);
        end_frame(1'b0, "good", PAY, CRC_POSIX, CRC_POSIX, 1'b1);

        // First transmitted payload bit flipped.
        exp_crc = crc_model(128'(PAY ^ {1'b1, 71'b0}), DWA);
        send(1'b0, {PAY ^ {1'b1, 71'b0}, CRC_POSIX}, 104);
        end_frame(1'b0, "bad", 128'(PAY ^ {1'b1, 71'b0}), CRC_POSIX, exp_crc, 1'b0);
        chk("bad.calc_differs", calc_a != CRC_POSIX, 1'b1);
`ifdef CRC_ERR_CNT_EN
        chk("bad.ecnt", ecnt_a, 1);
`endif

        // Back-to-back: good frame then all-zero payload (CRC = FFFFFFFF), enable held.
        nv0 = nval_a;
        nb0 = nbad_a;
        send(1'b0, {PAY, CRC_POSIX, 72'h0, 32'hFFFFFFFF}, 208);
        end_frame(1'b0, "b2b", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        chk("b2b.npulses", nval_a - nv0, 2);
        chk("b2b.spacing", t_val_a - t_prev_a, DWA + 32);
        chk("b2b.nbad", nbad_a - nb0, 0);

        // Abort: enable dropped where payload bit 40 would arrive.
        nv0 = nval_a;
        nf0 = nferr_a;
        send(1'b0, 256'(PAY >> 32), 40);
        @(negedge clk);
        en_a = 1'b0;
        chk("abort.busy_mid", busy_a, 1'b1);
        @(negedge clk);
        chk("abort.ferr", ferr_a, 1'b1);
        chk("abort.busy", busy_a, 1'b0);
        chk("abort.valid", valid_a, 1'b0);
        chk("abort.data_kept", data_a, 0);
        chk("abort.calc_kept", calc_a, 32'hFFFFFFFF);
        chk("abort.ok_kept", ok_a, 1'b1);
`ifdef CRC_ERR_CNT_EN
        chk("abort.ecnt", ecnt_a, 2);
`endif
        @(negedge clk);
        chk("abort.ferr_off", ferr_a, 1'b0);
        send(1'b0, {PAY, CRC_POSIX}, 104);
        end_frame(1'b0, "after_abort", PAY, CRC_POSIX, CRC_POSIX, 1'b1);
        chk("abort.nvalid", nval_a - nv0, 1);
        chk("abort.nferr", nferr_a - nf0, 1);

        // Asynchronous reset ten bits into the check field.
        send(1'b0, 256'({PAY, CRC_POSIX} >> 22), 82);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst.data", data_a, 0);
        chk("mid_rst.rx", rx_a, 0);
        chk("mid_rst.calc", calc_a, 0);
        chk("mid_rst.ok", ok_a, 0);
        chk("mid_rst.busy", busy_a, 0);
`ifdef CRC_ERR_CNT_EN
        chk("mid_rst.ecnt", ecnt_a, 0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        en_a = 1'b0;
        exp_crc = crc_model(128'(PAY3), DWA);
        send(1'b0, {PAY3, exp_crc}, 104);
        end_frame(1'b0, "post_rst", PAY3, exp_crc, exp_crc, 1'b1);

        // 128-bit instance: all-zero and all-one payloads.
        send(1'b1, {128'h0, 32'hFFFFFFFF}, 160);
        end_frame(1'b1, "w128_zero", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        exp_crc = crc_model({128{1'b1}}, DWB);
        send(1'b1, {{128{1'b1}}, exp_crc}, 160);
        end_frame(1'b1, "w128_ones", {128{1'b1}}, exp_crc, exp_crc, 1'b1);
`ifdef CRC_ERR_CNT_EN
        chk("w128.ecnt", ecnt_b, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
